// File: rtl/sample_writer.sv
// Decimated sample writer: stores ADC_DATA to SRAM on each CLK_EN through a wrapping
// address, with a pre/wait/post trigger sequence. Optional SAMPLE_WRITER_PEAK_DETECT_EN.
module sample_writer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 19
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                CLK_EN,
  input  logic [DATA_W-1:0]   ADC_DATA,
  input  logic                START,
  input  logic [ADDR_W-1:0]   PRE_CNT,
  input  logic [ADDR_W-1:0]   POST_CNT,
  input  logic                TRIG,
  output logic [ADDR_W-1:0]   SRAM_ADDR,
  output logic [2*DATA_W-1:0] SRAM_DATA,
  output logic                SRAM_WE,
  output logic [ADDR_W-1:0]   TRIG_ADDR,
  output logic                BUSY,
  output logic                DONE
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT_TRIG,
    S_POST,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t              state, state_next;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W-1:0]   pre_left;
  logic [ADDR_W-1:0]   post_left;
  logic                active;
  logic                wr_en;
  logic                trig_hit;
  logic [2*DATA_W-1:0] word;

`ifdef SAMPLE_WRITER_PEAK_DETECT_EN
  logic [DATA_W-1:0] run_max, run_min;
  logic [DATA_W-1:0] cur_max, cur_min;

  // The current cycle's sample joins the window being closed by this strobe.
  assign cur_max = (ADC_DATA > run_max) ? ADC_DATA : run_max;
  assign cur_min = (ADC_DATA < run_min) ? ADC_DATA : run_min;
  assign word    = {cur_max, cur_min};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      run_max <= '0;
      run_min <= '1;
    end else if (CLK_EN) begin
      run_max <= '0;
      run_min <= '1;
    end else begin
      run_max <= cur_max;
      run_min <= cur_min;
    end
  end
`else
  assign word = {ADC_DATA, ADC_DATA};
`endif

  assign active = (state == S_PRE) || (state == S_WAIT_TRIG) || (state == S_POST);
  assign wr_en  = CLK_EN && !START && active;
  assign BUSY   = active;
  assign DONE   = (state == S_DONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: defaults first keep this block free of inferred latches.
  always_comb begin
    state_next = state;
    trig_hit   = 1'b0;
    if (START) begin
      state_next = (PRE_CNT == '0) ? S_WAIT_TRIG : S_PRE;
    end else if (wr_en) begin
      unique case (state)
        S_PRE: begin
          if (pre_left == ONE) state_next = S_WAIT_TRIG;
        end
        S_WAIT_TRIG: begin
          if (TRIG) begin
            trig_hit   = 1'b1;
            state_next = (post_left == ONE) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          if (post_left == ONE) state_next = S_DONE;
        end
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr      <= '0;
      pre_left  <= '0;
      post_left <= '0;
      SRAM_ADDR <= '0;
      SRAM_DATA <= '0;
      SRAM_WE   <= 1'b0;
      TRIG_ADDR <= '0;
    end else begin
      SRAM_WE <= wr_en;
      if (START) begin
        addr      <= '0;
        pre_left  <= PRE_CNT;
        // A zero post count still records the trigger sample itself.
        post_left <= (POST_CNT == '0) ? ONE : POST_CNT;
      end else if (wr_en) begin
        SRAM_ADDR <= addr;
        SRAM_DATA <= word;
        addr      <= addr + ONE;
        if (state == S_PRE) pre_left <= pre_left - ONE;
        if ((state == S_POST) || trig_hit) post_left <= post_left - ONE;
        if (trig_hit) TRIG_ADDR <= addr;
      end
    end
  end

endmodule

// File: tb/tb_sample_writer.sv
// Self-checking bench for sample_writer (ADDR_W=4 to exercise wrap-around) against a
// record-level reference model; honours SAMPLE_WRITER_PEAK_DETECT_EN when defined.
module tb_sample_writer;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int VW = 1 + AW + 2*DW + 1 + 1 + AW;

  logic          CLK = 1'b0;
  logic          RST;
  logic          CLK_EN;
  logic [DW-1:0] ADC_DATA;
  logic          START;
  logic [AW-1:0] PRE_CNT;
  logic [AW-1:0] POST_CNT;
  logic          TRIG;
  logic [AW-1:0] SRAM_ADDR;
  logic [2*DW-1:0] SRAM_DATA;
  logic          SRAM_WE;
  logic [AW-1:0] TRIG_ADDR;
  logic          BUSY;
  logic          DONE;

  always #5 CLK = ~CLK;

  sample_writer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .CLK(CLK), .RST(RST), .CLK_EN(CLK_EN), .ADC_DATA(ADC_DATA), .START(START),
    .PRE_CNT(PRE_CNT), .POST_CNT(POST_CNT), .TRIG(TRIG),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DATA(SRAM_DATA), .SRAM_WE(SRAM_WE),
    .TRIG_ADDR(TRIG_ADDR), .BUSY(BUSY), .DONE(DONE)
  );

  int n_checks = 0;
  int n_errors = 0;
  int we_seen  = 0;

  // Reference model: a record is a count of stored samples plus trigger bookkeeping.
  bit              m_armed, m_done, m_trig, m_we;
  int              m_idx, m_pre, m_post, m_pw;
  logic [AW-1:0]   m_addr, m_trig_addr;
  logic [2*DW-1:0] m_data;
  logic [DW-1:0]   m_max, m_min;

  function automatic logic [VW-1:0] dut_vec();
    return {SRAM_WE, SRAM_ADDR, SRAM_DATA, BUSY, DONE, TRIG_ADDR};
  endfunction

  function automatic logic [VW-1:0] m_vec();
    return {m_we, m_addr, m_data, m_armed, m_done, m_trig_addr};
  endfunction

  task automatic model_reset();
    m_armed = 0; m_done = 0; m_trig = 0; m_we = 0;
    m_idx = 0; m_pre = 0; m_post = 0; m_pw = 0;
    m_addr = '0; m_trig_addr = '0; m_data = '0;
    m_max = '0; m_min = '1;
  endtask

  task automatic step(input logic en, input logic [DW-1:0] d, input logic st,
                      input logic tg, input logic [AW-1:0] pre, input logic [AW-1:0] post);
    logic [DW-1:0] hi, lo;
    CLK_EN = en; ADC_DATA = d; START = st; TRIG = tg; PRE_CNT = pre; POST_CNT = post;
    @(posedge CLK);
`ifdef SAMPLE_WRITER_PEAK_DETECT_EN
    hi = (d > m_max) ? d : m_max;
    lo = (d < m_min) ? d : m_min;
    if (en) begin m_max = '0; m_min = '1; end
    else    begin m_max = hi; m_min = lo; end
`else
    hi = d;
    lo = d;
`endif
    m_we = 0;
    if (st) begin
      m_armed = 1; m_done = 0; m_trig = 0; m_idx = 0; m_pw = 0;
      m_pre  = int'(pre);
      m_post = (post == '0) ? 1 : int'(post);
    end else if (en && m_armed) begin
      m_we   = 1;
      m_addr = AW'(m_idx);
      m_data = {hi, lo};
      if (m_idx >= m_pre && !m_trig && tg) begin
        m_trig      = 1;
        m_trig_addr = m_addr;
      end
      if (m_trig) m_pw++;
      if (m_trig && m_pw == m_post) begin
        m_armed = 0;
        m_done  = 1;
      end
      m_idx++;
    end
    #1;
    if (SRAM_WE === 1'b1) we_seen++;
  endtask

  task automatic test_reset();
    RST = 1'b1; CLK_EN = 0; ADC_DATA = '0; START = 0; TRIG = 0; PRE_CNT = '0; POST_CNT = '0;
    model_reset();
    #12;
    n_checks++;
    if (dut_vec() !== '0) begin
      n_errors++;
      $display("FAIL reset_state: got %h want %h", dut_vec(), {VW{1'b0}});
    end
    @(negedge CLK);
    RST = 1'b0;
    step(1, 8'h33, 0, 1, '0, '0);
    n_checks++;
    if (dut_vec() !== m_vec()) begin
      n_errors++;
      $display("FAIL idle_after_reset: got %h want %h", dut_vec(), m_vec());
    end
  endtask

  task automatic test_basic_record();
    bit done_seen = 0;
    logic done_we = 0;
    logic [AW-1:0] done_addr = '0;
    we_seen = 0;
    step(0, 8'h00, 1, 0, 4'd4, 4'd3);
    for (int s = 1; s <= 12; s++) begin
      for (int c = 0; c < 3; c++) begin
        step(c == 2, 8'($urandom), 0, s >= 7, '0, '0);
        n_checks++;
        if (dut_vec() !== m_vec()) begin
          n_errors++;
          $display("FAIL basic s%0d c%0d: got %h want %h", s, c, dut_vec(), m_vec());
        end
        if (DONE === 1'b1 && !done_seen) begin
          done_seen = 1; done_we = SRAM_WE; done_addr = SRAM_ADDR;
        end
      end
    end
    n_checks++;
    if (we_seen != 9) begin n_errors++; $display("FAIL basic_we_count: got %0d want 9", we_seen); end
    n_checks++;
    if (TRIG_ADDR !== 4'd6) begin n_errors++; $display("FAIL basic_trig_addr: got %0d want 6", TRIG_ADDR); end
    n_checks++;
    if (!(done_seen && done_we === 1'b1 && done_addr === 4'd8)) begin
      n_errors++;
      $display("FAIL basic_done_edge: seen=%0d we=%b addr=%0d want 1/1/8", done_seen, done_we, done_addr);
    end
    n_checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b1) begin
      n_errors++; $display("FAIL basic_final: busy=%b done=%b want 0/1", BUSY, DONE);
    end
  endtask

  task automatic test_wrap();
    we_seen = 0;
    step(0, 8'h00, 1, 0, 4'd2, 4'd2);
    for (int s = 0; s < 30; s++) begin
      step(1, 8'($urandom), 0, s == 20, '0, '0);
      n_checks++;
      if (dut_vec() !== m_vec()) begin
        n_errors++;
        $display("FAIL wrap s%0d: got %h want %h", s, dut_vec(), m_vec());
      end
    end
    n_checks++;
    if (TRIG_ADDR !== 4'd4) begin n_errors++; $display("FAIL wrap_trig_addr: got %0d want 4", TRIG_ADDR); end
    n_checks++;
    if (we_seen != 22 || DONE !== 1'b1) begin
      n_errors++; $display("FAIL wrap_count: writes=%0d done=%b want 22/1", we_seen, DONE);
    end
  endtask

  task automatic test_edge_counts();
    we_seen = 0;
    step(1, 8'h44, 1, 1, 4'd0, 4'd0);
    n_checks++;
    if (BUSY !== 1'b1 || SRAM_WE !== 1'b0) begin
      n_errors++; $display("FAIL edge_start: busy=%b we=%b want 1/0", BUSY, SRAM_WE);
    end
    for (int s = 0; s < 3; s++) begin
      step(1, 8'($urandom), 0, 1, '0, '0);
      n_checks++;
      if (dut_vec() !== m_vec()) begin
        n_errors++;
        $display("FAIL edge s%0d: got %h want %h", s, dut_vec(), m_vec());
      end
    end
    n_checks++;
    if (we_seen != 1 || TRIG_ADDR !== 4'd0 || DONE !== 1'b1 || SRAM_ADDR !== 4'd0) begin
      n_errors++;
      $display("FAIL edge_result: writes=%0d trig=%0d done=%b addr=%0d want 1/0/1/0",
               we_seen, TRIG_ADDR, DONE, SRAM_ADDR);
    end
  endtask

  task automatic test_restart_reset();
    int held;
    step(0, 8'h00, 1, 0, 4'd2, 4'd15);
    for (int s = 0; s <= 10; s++) begin
      step(1, 8'($urandom), 0, s == 4, '0, '0);
      n_checks++;
      if (dut_vec() !== m_vec()) begin
        n_errors++;
        $display("FAIL restart s%0d: got %h want %h", s, dut_vec(), m_vec());
      end
    end
    step(1, 8'h55, 1, 0, 4'd3, 4'd3);
    n_checks++;
    if (BUSY !== 1'b1 || DONE !== 1'b0 || SRAM_WE !== 1'b0 || TRIG_ADDR !== 4'd4) begin
      n_errors++;
      $display("FAIL restart_start: busy=%b done=%b we=%b trig=%0d want 1/0/0/4",
               BUSY, DONE, SRAM_WE, TRIG_ADDR);
    end
    step(1, 8'h66, 0, 0, '0, '0);
    n_checks++;
    if (SRAM_WE !== 1'b1 || SRAM_ADDR !== 4'd0) begin
      n_errors++; $display("FAIL restart_first: we=%b addr=%0d want 1/0", SRAM_WE, SRAM_ADDR);
    end
    step(1, 8'h77, 0, 0, '0, '0);
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (dut_vec() !== '0) begin
      n_errors++; $display("FAIL async_reset: got %h want %h", dut_vec(), {VW{1'b0}});
    end
    step(1, 8'h88, 0, 0, '0, '0);
    RST = 1'b0;
    held = we_seen;
    for (int s = 0; s < 4; s++) begin
      step(1, 8'($urandom), 0, 1, '0, '0);
      n_checks++;
      if (dut_vec() !== m_vec()) begin
        n_errors++;
        $display("FAIL post_reset s%0d: got %h want %h", s, dut_vec(), m_vec());
      end
    end
    n_checks++;
    if (we_seen != held) begin
      n_errors++; $display("FAIL post_reset_writes: got %0d want %0d", we_seen - held, 0);
    end
  endtask

  task automatic test_peak();
    logic [DW-1:0] seq [6] = '{8'd7, 8'd10, 8'd200, 8'd5, 8'd90, 8'd50};
    logic [2*DW-1:0] want1, want2;
`ifdef SAMPLE_WRITER_PEAK_DETECT_EN
    want1 = {8'd200, 8'd5};
    want2 = {8'd60, 8'd50};
`else
    want1 = {8'd90, 8'd90};
    want2 = {8'd60, 8'd60};
`endif
    step(0, 8'h00, 1, 0, 4'd15, 4'd15);
    for (int i = 0; i < 6; i++) begin
      step(i == 0 || i == 4, seq[i], 0, 0, '0, '0);
      n_checks++;
      if (dut_vec() !== m_vec()) begin
        n_errors++;
        $display("FAIL peak i%0d: got %h want %h", i, dut_vec(), m_vec());
      end
      if (i == 4) begin
        n_checks++;
        if (SRAM_DATA !== want1) begin
          n_errors++; $display("FAIL peak_word: got %h want %h", SRAM_DATA, want1);
        end
      end
    end
    step(1, 8'd60, 0, 0, '0, '0);
    n_checks++;
    if (SRAM_DATA !== want2) begin
      n_errors++; $display("FAIL peak_next_window: got %h want %h", SRAM_DATA, want2);
    end
  endtask

  task automatic test_trig_gating();
    logic [AW-1:0] prev_trig;
    we_seen = 0;
    prev_trig = TRIG_ADDR;
    step(0, 8'h00, 1, 1, 4'd3, 4'd2);
    for (int s = 0; s < 3; s++) begin
      step(0, 8'($urandom), 0, 1, '0, '0);
      step(1, 8'($urandom), 0, 1, '0, '0);
    end
    for (int s = 0; s < 10; s++) begin
      step(1, 8'($urandom), 0, 0, '0, '0);
      step(0, 8'($urandom), 0, 1, '0, '0);
      n_checks++;
      if (dut_vec() !== m_vec()) begin
        n_errors++;
        $display("FAIL gating s%0d: got %h want %h", s, dut_vec(), m_vec());
      end
    end
    n_checks++;
    if (BUSY !== 1'b1 || DONE !== 1'b0 || we_seen != 13 || TRIG_ADDR !== prev_trig) begin
      n_errors++;
      $display("FAIL gating_state: busy=%b done=%b writes=%0d trig=%0d want 1/0/13/%0d",
               BUSY, DONE, we_seen, TRIG_ADDR, prev_trig);
    end
    step(1, 8'h11, 0, 1, '0, '0);
    step(1, 8'h22, 0, 0, '0, '0);
    n_checks++;
    if (DONE !== 1'b1 || TRIG_ADDR !== 4'd13) begin
      n_errors++; $display("FAIL gating_finish: done=%b trig=%0d want 1/13", DONE, TRIG_ADDR);
    end
  endtask

  task automatic test_random();
    step(0, 8'h00, 1, 0, 4'($urandom), 4'($urandom));
    for (int c = 0; c < 500; c++) begin
      step($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 59) == 0,
           $urandom_range(0, 5) == 0, 4'($urandom), 4'($urandom));
      n_checks++;
      if (dut_vec() !== m_vec()) begin
        n_errors++;
        $display("FAIL random c%0d: got %h want %h", c, dut_vec(), m_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_record();
    test_wrap();
    test_edge_counts();
    test_restart_reset();
    test_peak();
    test_trig_gating();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/sample_writer.md
# sample_writer

Acquisition-side consumer of the decimation strobe. Captures `ADC_DATA` on every `CLK_EN` pulse and writes it to external sample SRAM through a wrapping address counter. A pre-trigger / wait-trigger / post-trigger state machine decides when the record is complete. Sits between the decimation counter (`CLK_EN` source) and the SRAM bus; the host read-out logic uses `TRIG_ADDR` and `DONE`.

## Interface
- `DATA_W`, default 8: ADC sample width.
- `ADDR_W`, default 19: SRAM address width; also the width of the pre/post counts.
- `CLK`  in  1: sampling clock; all logic on its rising edge.
- `RST`  in  1: asynchronous, active-high reset.
- `CLK_EN`  in  1: one-cycle decimation strobe; each high cycle marks one stored sample.
- `ADC_DATA`  in  DATA_W: unsigned sample, valid every cycle.
- `START`  in  1: one-cycle arm pulse.
- `PRE_CNT`  in  ADDR_W: samples to store before the trigger is accepted; latched on `START`.
- `POST_CNT`  in  ADDR_W: samples to store from the trigger sample onward; latched on `START`.
- `TRIG`  in  1: trigger level, already synchronous to `CLK`.
- `SRAM_ADDR`  out  ADDR_W: write address.
- `SRAM_DATA`  out  2*DATA_W: write word, `{max, min}`.
- `SRAM_WE`  out  1: one-cycle write strobe.
- `TRIG_ADDR`  out  ADDR_W: address of the trigger sample.
- `BUSY`  out  1: high from PRE through POST.
- `DONE`  out  1: record complete; held high until the next `START` or `RST`.

## Operation
- States:
  - IDLE: reset state. `START` -> PRE, or -> WAIT_TRIG if `PRE_CNT` = 0.
  - PRE: stores samples. After `PRE_CNT` writes -> WAIT_TRIG.
  - WAIT_TRIG: keeps storing. If `TRIG` = 1 on a `CLK_EN` cycle, that sample becomes the trigger sample -> POST.
  - POST: stores samples. After max(`POST_CNT`, 1) writes (the trigger sample counts as the first) -> DONE.
  - DONE: no writes. `START` -> PRE or WAIT_TRIG, same rule as from IDLE.
- `TRIG` is ignored in IDLE, PRE, POST and DONE. It is sampled only on `CLK_EN` cycles.
- `START` in any state, including mid-record, restarts the record:
  - address := 0; counters reloaded; `DONE` := 0; `TRIG_ADDR` unchanged.
  - A `CLK_EN` in the same cycle as `START` is not stored.
- Address rules:
  - Address increments by 1 after each write.
  - Wraps from 2^ADDR_W-1 to 0 with no flag, so WAIT_TRIG behaves as a circular buffer.
  - `TRIG_ADDR` is loaded with the address used for the trigger sample.
- Counters are ADDR_W bits and count down. `PRE_CNT`/`POST_CNT` = 2^ADDR_W-1 is legal.
- `CLK_EN` outside PRE/WAIT_TRIG/POST: no write; accumulators still reload (see Configuration).

## Timing
- Write latency: `CLK_EN` high at edge n -> at edge n+1, `SRAM_WE` = 1 for exactly one cycle with `SRAM_ADDR` and `SRAM_DATA` valid. All three are registered.
- `SRAM_ADDR` and `SRAM_DATA` hold their values between writes.
- The state transition caused by the last write of a phase takes effect at the same edge as that write's `SRAM_WE`.
  - `DONE` rises together with the final `SRAM_WE`.
  - `BUSY` falls together with the final `SRAM_WE`.
- `START` at edge n -> `BUSY` = 1 from edge n+1. The first storable `CLK_EN` is at edge n+1 or later.
- Back-to-back `CLK_EN` (decimation 0, strobe every cycle) is supported: one write per cycle, no drops.
- Reset values: `SRAM_ADDR` = 0, `SRAM_DATA` = 0, `SRAM_WE` = 0, `TRIG_ADDR` = 0, `BUSY` = 0, `DONE` = 0, state IDLE.
- Reset mid-record aborts with no further writes.

## Configuration
- `SAMPLE_WRITER_PEAK_DETECT_EN` defined:
  - Unsigned running max and min of `ADC_DATA` are tracked every cycle.
  - On a `CLK_EN` cycle the written word is `{max(run_max, ADC_DATA), min(run_min, ADC_DATA)}`.
  - The accumulators are then reloaded so the next window starts with the next cycle's sample.
  - Accumulators reset to max = 0 and min = all-ones.
- Not defined:
  - `SRAM_DATA` = `{ADC_DATA, ADC_DATA}` as sampled on the `CLK_EN` cycle.
  - No accumulator logic is present.

## Test plan
- Basic record: `PRE_CNT` = 4, `POST_CNT` = 3, `CLK_EN` every 3rd cycle, `TRIG` = 1 from the 7th strobe. Expect 4 PRE writes at addresses 0-3, then WAIT_TRIG writes at 4-5, then trigger write at 6 with `TRIG_ADDR` = 6. Post writes end at 8; `DONE` = 1 with the addr-8 write; exactly 9 `SRAM_WE` pulses.
- Wrap-around: `ADDR_W` = 4, `PRE_CNT` = 2, trigger after 20 strobes. Expect addresses 0..15, 0..3, ...; `TRIG_ADDR` = 4 (the 21st write); no glitch at the wrap.
- Edge counts: `PRE_CNT` = 0, `POST_CNT` = 0, `TRIG` = 1, strobe every cycle. Expect WAIT_TRIG right after `START`; a single write at addr 0; `DONE` after 1 write; `TRIG_ADDR` = 0.
- Restart/reset: `START` during POST at addr 10. Expect next write at addr 0, `DONE` = 0, `BUSY` = 1. Then assert `RST` asynchronously mid-cycle: all outputs go to 0 immediately and no `SRAM_WE` follows.
- Peak detect (macro defined): samples 10, 200, 5, 90 with `CLK_EN` on the 90 cycle. Expect `SRAM_DATA` = {200, 5}; the next window starts fresh. Without the macro, the same stimulus gives {90, 90}.
- Trigger gating: `TRIG` high only on non-`CLK_EN` cycles, or high during PRE. Expect no transition to POST; `BUSY` stays 1 and writes continue.
